dose_scheduler: RTL and testbench
=================================

Name: dose_scheduler

Overview:
- Sequences the medication-reminder datapath for one patient.
- On a load request, fetches the patient's dose record from the patient ROM, then counts down the dose interval on 1 Hz ticks and raises an alarm at each dose time.
- Tracks acknowledged and missed doses and stops once the prescribed dose count is reached.
- Sits between the front-panel control logic (patient ID, run/reset) and the clock/display path; drives the ROM address and the alarm LED/buzzer.

Parameters:
- ROM_LATENCY, 2, cycles from romAddr valid to romData valid (1..7).
- ALARM_TIMEOUT_SEC, 60, seconds an alarm stays up before the dose is counted missed (1..255).
- SNOOZE_SEC, 300, snooze delay in seconds; used only with SNOOZE_EN (1..4095).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- secTick  in  1  one-cycle pulse, once per second, from the clock module.
- run  in  1  level; 1 = countdown enabled (start pressed), 0 = paused.
- loadReq  in  1  one-cycle pulse: latch patientId and fetch its record.
- patientId  in  8  patient ROM address.
- romAddr  out  8  address to the patient ROM.
- romData  in  16  ROM word: [15:12] maxDoses, [11:0] interval in minutes.
- ack  in  1  one-cycle pulse: patient acknowledged the dose.
- snooze  in  1  one-cycle pulse; ignored unless SNOOZE_EN.
- alarm  out  1  dose-due indicator.
- doseCount  out  4  doses acknowledged.
- missedCount  out  4  doses timed out.
- remainingSec  out  18  seconds to the next alarm.
- state  out  3  encoded FSM state: IDLE=0, FETCH=1, ARMED=2, ALARM=3, DONE=4.
- done  out  1  1 while in DONE.

Behaviour:
- Reset: asserted at any time, including mid-FETCH or mid-ALARM.
  - Next state IDLE; romAddr=0, alarm=0, doseCount=0, missedCount=0, remainingSec=0, done=0, latency counter=0, timeout counter=0, snooze flag=0.
- Only one state transition per clock.
- IDLE:
  - loadReq → FETCH; romAddr <= patientId, latency counter cleared.
  - Other inputs are ignored.
- FETCH:
  - Counts ROM_LATENCY cycles after entry, then samples romData and registers maxDoses and interval.
  - Interval 0 is clamped to 1 minute.
  - If maxDoses=0 → DONE; otherwise remainingSec <= interval*60 (max 245700, fits 18 bits) → ARMED.
  - loadReq during FETCH is ignored.
- ARMED:
  - On secTick with run=1: if remainingSec>1, decrement; if remainingSec==1, set remainingSec=0 and alarm=1, clear timeout counter → ALARM.
  - With run=0, remainingSec holds.
  - loadReq in ARMED → FETCH with the new patientId; counts are cleared. This is the only re-load path outside IDLE/DONE.
- ALARM:
  - alarm=1 throughout.
  - ack → alarm=0, doseCount+1.
  - Else, on secTick: timeout counter+1. When it reaches ALARM_TIMEOUT_SEC → alarm=0, missedCount+1.
  - ack and the timeout tick in the same cycle: ack wins; the dose is counted acknowledged.
  - After either outcome: if doseCount+missedCount (post-update) ≥ maxDoses → DONE; else remainingSec <= interval*60 → ARMED.
  - run is ignored in ALARM; the timeout counts regardless.
  - doseCount and missedCount saturate at 15.
- DONE:
  - done=1, alarm=0, remainingSec=0.
  - loadReq → FETCH with counts cleared.
- Latency: loadReq to ARMED is ROM_LATENCY+2 cycles. secTick to alarm rise is 1 cycle.

Optional Feature:
- Macro: DOSE_SCHED_SNOOZE_EN.
- Defined: snooze in ALARM, when the per-dose snooze flag is 0:
  - alarm=0, remainingSec <= SNOOZE_SEC, snooze flag set → ARMED; no count changes.
  - A second snooze for the same dose is ignored.
  - The flag clears on ack or timeout.
- Undefined: the snooze port is present but unused; no snooze flag register.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..DONE);
  - ROM word field positions (MAXDOSE_MSB/LSB, INTERVAL_MSB/LSB);
  - SEC_PER_MIN=60;
  - REMAIN_W=18.
- One natural sub-module, sched_rom_wait: the ROM_LATENCY cycle counter. It takes start and outputs a one-cycle ready pulse.

Test Plan:
- Reset, then load patientId=0x05 with romData=0x3001 (3 doses, 1 min), run=1 → after ROM_LATENCY+2 cycles state=ARMED, remainingSec=60; after 60 secTicks alarm=1.
- In ALARM, pulse ack → alarm=0, doseCount=1, remainingSec=60. Repeat for 3 doses → done=1, state=DONE.
- romData=0x2001, ignore alarm for 60 ticks → missedCount=1, re-armed. Second miss → DONE with missedCount=2, doseCount=0.
- ack and the 60th timeout tick in the same cycle → doseCount+1, missedCount unchanged. Separately, run=0 for 10 ticks in ARMED → remainingSec unchanged.
- romData=0x1000 (interval 0) → remainingSec=60. romData=0x0005 → DONE directly from FETCH.
- Reset asserted mid-ALARM, asynchronous to clk → outputs zero immediately, state=IDLE. With DOSE_SCHED_SNOOZE_EN: snooze → remainingSec=300, and a second snooze at the next alarm of the same dose is ignored.

Source files
------------

// File: rtl/dose_scheduler_pkg.sv
// Shared definitions for the dose scheduler slice.
//   schedState_t : FSM state encoding, also driven out on the state port
//   ROM word     : [MAXDOSE_MSB:MAXDOSE_LSB] max doses, [INTERVAL_MSB:INTERVAL_LSB] minutes
//   minToSec()   : dose interval in minutes -> countdown seconds
package dose_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ARMED = 3'd2,
      ALARM = 3'd3,
      DONE  = 3'd4
   } schedState_t;

   localparam int unsigned MAXDOSE_MSB  = 15;
   localparam int unsigned MAXDOSE_LSB  = 12;
   localparam int unsigned INTERVAL_MSB = 11;
   localparam int unsigned INTERVAL_LSB = 0;

   localparam int unsigned SEC_PER_MIN = 60;
   localparam int unsigned REMAIN_W    = 18;

   // 4095 min * 60 = 245700, which fits in REMAIN_W bits.
   function automatic logic [REMAIN_W-1:0] minToSec(
      input logic [INTERVAL_MSB-INTERVAL_LSB:0] minutes
   );
      return REMAIN_W'(minutes) * REMAIN_W'(SEC_PER_MIN);
   endfunction

endpackage

// File: rtl/sched_rom_wait.sv
// ROM access latency counter for the dose scheduler.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle pulse issued together with the new ROM address
//   ready      : one-cycle pulse in the cycle in which romData is valid,
//                i.e. LATENCY cycles after the address register updates
module sched_rom_wait
   import dose_scheduler_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic ready
);

   localparam logic [2:0] LAST = 3'(LATENCY);

   logic [2:0] cnt;
   logic       busy;

   assign ready = busy && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         if (ready) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/dose_scheduler.sv
// Medication-reminder sequencer for one patient.
// Fetches the patient's dose record from ROM, counts the dose interval down
// on 1 Hz ticks, raises the alarm at each dose time and tallies acknowledged
// and missed doses until the prescribed count is reached.
//   clk, reset              : clock, asynchronous active-high reset
//   secTick                 : 1 Hz one-cycle pulse
//   run                     : countdown enable level
//   loadReq, patientId      : load pulse and ROM address to fetch
//   romAddr, romData        : patient ROM interface
//   ack, snooze             : patient responses to an alarm
//   alarm, done, state      : status (state uses schedState_t encoding)
//   doseCount, missedCount  : saturating dose tallies
//   remainingSec            : seconds until the next alarm
// Optional feature: define DOSE_SCHED_SNOOZE_EN to enable one snooze per dose.
module dose_scheduler
   import dose_scheduler_pkg::*;
#(
   parameter int unsigned ROM_LATENCY       = 2,
   parameter int unsigned ALARM_TIMEOUT_SEC = 60,
   parameter int unsigned SNOOZE_SEC        = 300
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                secTick,
   input  logic                run,
   input  logic                loadReq,
   input  logic [7:0]          patientId,
   output logic [7:0]          romAddr,
   input  logic [15:0]         romData,
   input  logic                ack,
   input  logic                snooze,
   output logic                alarm,
   output logic [3:0]          doseCount,
   output logic [3:0]          missedCount,
   output logic [REMAIN_W-1:0] remainingSec,
   output logic [2:0]          state,
   output logic                done
);

   localparam int unsigned MAXDOSE_W    = MAXDOSE_MSB - MAXDOSE_LSB + 1;
   localparam int unsigned INTERVAL_W   = INTERVAL_MSB - INTERVAL_LSB + 1;
   localparam logic [7:0]  TIMEOUT_LAST = 8'(ALARM_TIMEOUT_SEC - 1);

   schedState_t           stateQ, stateNext;
   logic [7:0]            romAddrQ, romAddrNext;
   logic [MAXDOSE_W-1:0]  maxDosesQ, maxDosesNext;
   logic [INTERVAL_W-1:0] intervalQ, intervalNext;
   logic [3:0]            doseQ, doseNext, missQ, missNext;
   logic [REMAIN_W-1:0]   remQ, remNext;
   logic [7:0]            timeoutQ, timeoutNext;
   logic                  startFetch, romReady, resolved;
   logic [3:0]            doseInc, missInc;
   logic [4:0]            total;
   logic [MAXDOSE_W-1:0]  romMax;
   logic [INTERVAL_W-1:0] romInterval;

`ifdef DOSE_SCHED_SNOOZE_EN
   logic snoozeFlagQ, snoozeFlagNext;
`else
   logic unusedSnooze;
   localparam int unsigned unusedSnoozeSec = SNOOZE_SEC;
   assign unusedSnooze = snooze;
`endif

   assign romMax      = romData[MAXDOSE_MSB:MAXDOSE_LSB];
   assign romInterval = romData[INTERVAL_MSB:INTERVAL_LSB];
   assign doseInc     = (doseQ == '1) ? doseQ : doseQ + 4'd1;
   assign missInc     = (missQ == '1) ? missQ : missQ + 4'd1;

   sched_rom_wait #(
      .LATENCY(ROM_LATENCY)
   ) romWait (
      .clk  (clk),
      .reset(reset),
      .start(startFetch),
      .ready(romReady)
   );

   always_comb begin
      stateNext    = stateQ;
      romAddrNext  = romAddrQ;
      maxDosesNext = maxDosesQ;
      intervalNext = intervalQ;
      doseNext     = doseQ;
      missNext     = missQ;
      remNext      = remQ;
      timeoutNext  = timeoutQ;
      startFetch   = 1'b0;
      resolved     = 1'b0;
      total        = '0;
`ifdef DOSE_SCHED_SNOOZE_EN
      snoozeFlagNext = snoozeFlagQ;
`endif

      case (stateQ)
         IDLE: startFetch = loadReq;

         FETCH: begin
            if (romReady) begin
               maxDosesNext = romMax;
               intervalNext = (romInterval == '0) ? INTERVAL_W'(1) : romInterval;
               if (romMax == '0) begin
                  remNext   = '0;
                  stateNext = DONE;
               end else begin
                  remNext   = minToSec(intervalNext);
                  stateNext = ARMED;
               end
            end
         end

         ARMED: begin
            if (loadReq) begin
               startFetch = 1'b1;
            end else if (secTick && run) begin
               if (remQ > REMAIN_W'(1)) begin
                  remNext = remQ - REMAIN_W'(1);
               end else begin
                  remNext     = '0;
                  timeoutNext = '0;
                  stateNext   = ALARM;
               end
            end
         end

         ALARM: begin
            // Priority: ack, then snooze, then the timeout tick.
            if (ack) begin
               doseNext = doseInc;
               resolved = 1'b1;
`ifdef DOSE_SCHED_SNOOZE_EN
            end else if (snooze && !snoozeFlagQ) begin
               snoozeFlagNext = 1'b1;
               remNext        = REMAIN_W'(SNOOZE_SEC);
               stateNext      = ARMED;
`endif
            end else if (secTick) begin
               timeoutNext = timeoutQ + 8'd1;
               if (timeoutQ == TIMEOUT_LAST) begin
                  missNext = missInc;
                  resolved = 1'b1;
               end
            end

            if (resolved) begin
`ifdef DOSE_SCHED_SNOOZE_EN
               snoozeFlagNext = 1'b0;
`endif
               total = 5'(doseNext) + 5'(missNext);
               if (total >= 5'(maxDosesQ)) begin
                  remNext   = '0;
                  stateNext = DONE;
               end else begin
                  remNext   = minToSec(intervalQ);
                  stateNext = ARMED;
               end
            end
         end

         DONE: startFetch = loadReq;

         default: stateNext = IDLE;
      endcase

      // Every accepted load restarts the record fetch with fresh tallies;
      // remainingSec is left as-is until the new record arrives.
      if (startFetch) begin
         stateNext   = FETCH;
         romAddrNext = patientId;
         doseNext    = '0;
         missNext    = '0;
`ifdef DOSE_SCHED_SNOOZE_EN
         snoozeFlagNext = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ    <= IDLE;
         romAddrQ  <= '0;
         maxDosesQ <= '0;
         intervalQ <= '0;
         doseQ     <= '0;
         missQ     <= '0;
         remQ      <= '0;
         timeoutQ  <= '0;
`ifdef DOSE_SCHED_SNOOZE_EN
         snoozeFlagQ <= 1'b0;
`endif
      end else begin
         stateQ    <= stateNext;
         romAddrQ  <= romAddrNext;
         maxDosesQ <= maxDosesNext;
         intervalQ <= intervalNext;
         doseQ     <= doseNext;
         missQ     <= missNext;
         remQ      <= remNext;
         timeoutQ  <= timeoutNext;
`ifdef DOSE_SCHED_SNOOZE_EN
         snoozeFlagQ <= snoozeFlagNext;
`endif
      end
   end

   assign state        = stateQ;
   assign romAddr      = romAddrQ;
   assign alarm        = (stateQ == ALARM);
   assign done         = (stateQ == DONE);
   assign doseCount    = doseQ;
   assign missedCount  = missQ;
   assign remainingSec = remQ;

endmodule

// File: tb/tb_dose_scheduler.sv
// Self-checking bench for dose_scheduler: a behavioural model of the
// scheduling rules is compared against the DUT on every falling edge, and
// directed scenarios add literal expectations. Define DOSE_SCHED_SNOOZE_EN
// to exercise the snooze feature.
module tb_dose_scheduler;

   localparam int unsigned L   = 2;
   localparam int unsigned TO  = 60;
   localparam int unsigned SNZ = 300;

   logic        clk = 1'b0;
   logic        reset, secTick, run, loadReq, ack, snooze;
   logic [7:0]  patientId, romAddr;
   logic [15:0] romData;
   logic        alarm, done;
   logic [3:0]  doseCount, missedCount;
   logic [17:0] remainingSec;
   logic [2:0]  state;

   int checks   = 0;
   int failures = 0;
   bit cmpEn    = 1'b0;

   always #5 clk = ~clk;

   dose_scheduler #(
      .ROM_LATENCY      (L),
      .ALARM_TIMEOUT_SEC(TO),
      .SNOOZE_SEC       (SNZ)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .secTick     (secTick),
      .run         (run),
      .loadReq     (loadReq),
      .patientId   (patientId),
      .romAddr     (romAddr),
      .romData     (romData),
      .ack         (ack),
      .snooze      (snooze),
      .alarm       (alarm),
      .doseCount   (doseCount),
      .missedCount (missedCount),
      .remainingSec(remainingSec),
      .state       (state),
      .done        (done)
   );

   // Patient ROM: data appears L cycles after the address.
   logic [15:0] romTable [256];
   logic [15:0] romPipe  [L];

   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) romPipe[i] <= romPipe[i-1];
      romPipe[0] <= romTable[romAddr];
   end
   assign romData = romPipe[L-1];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: states 0..4 = IDLE, FETCH, ARMED, ALARM, DONE.
   int mState = 0, mAddr = 0, mFetch = 0, mMax = 0, mIntv = 0;
   int mRem = 0, mDose = 0, mMiss = 0, mTo = 0;
`ifdef DOSE_SCHED_SNOOZE_EN
   int mSnz = 0;
`endif

   always @(posedge clk or posedge reset) begin : model
      logic [15:0] word;
      bit doLoad, resolvedM;
      if (reset) begin
         mState = 0; mAddr = 0; mFetch = 0; mRem = 0;
         mDose = 0; mMiss = 0; mTo = 0;
`ifdef DOSE_SCHED_SNOOZE_EN
         mSnz = 0;
`endif
      end else begin
         doLoad = 1'b0;
         resolvedM = 1'b0;
         case (mState)
            0: doLoad = loadReq;
            1: begin
               mFetch++;
               if (mFetch == L + 1) begin
                  word  = romTable[mAddr];
                  mMax  = int'(word[15:12]);
                  mIntv = int'(word[11:0]);
                  if (mIntv == 0) mIntv = 1;
                  if (mMax == 0) begin mState = 4; mRem = 0; end
                  else begin mState = 2; mRem = mIntv * 60; end
               end
            end
            2: begin
               if (loadReq) doLoad = 1'b1;
               else if (secTick && run) begin
                  if (mRem > 1) mRem--;
                  else begin mRem = 0; mTo = 0; mState = 3; end
               end
            end
            3: begin
               if (ack) begin
                  mDose = (mDose < 15) ? mDose + 1 : 15;
                  resolvedM = 1'b1;
               end
`ifdef DOSE_SCHED_SNOOZE_EN
               else if (snooze && mSnz == 0) begin
                  mSnz = 1; mRem = SNZ; mState = 2;
               end
`endif
               else if (secTick) begin
                  mTo++;
                  if (mTo == TO) begin
                     mMiss = (mMiss < 15) ? mMiss + 1 : 15;
                     resolvedM = 1'b1;
                  end
               end
               if (resolvedM) begin
`ifdef DOSE_SCHED_SNOOZE_EN
                  mSnz = 0;
`endif
                  if (mDose + mMiss >= mMax) begin mState = 4; mRem = 0; end
                  else begin mState = 2; mRem = mIntv * 60; end
               end
            end
            default: doLoad = loadReq;
         endcase
         if (doLoad) begin
            mState = 1; mAddr = int'(patientId); mFetch = 0;
            mDose = 0; mMiss = 0;
`ifdef DOSE_SCHED_SNOOZE_EN
            mSnz = 0;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (cmpEn && !reset) begin
         chk("cyc.state",   int'(state),        mState);
         chk("cyc.romAddr", int'(romAddr),      mAddr);
         chk("cyc.alarm",   int'(alarm),        int'(mState == 3));
         chk("cyc.done",    int'(done),         int'(mState == 4));
         chk("cyc.dose",    int'(doseCount),    mDose);
         chk("cyc.missed",  int'(missedCount),  mMiss);
         chk("cyc.remain",  int'(remainingSec), mRem);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseLoad(input logic [7:0] id);
      patientId = id; loadReq = 1'b1; cycle(); loadReq = 1'b0;
   endtask

   task automatic sec(input int n);
      repeat (n) begin
         secTick = 1'b1; cycle(); secTick = 1'b0; cycle();
      end
   endtask

   task automatic pulseAck();
      ack = 1'b1; cycle(); ack = 1'b0;
   endtask

   task automatic pulseSnooze();
      snooze = 1'b1; cycle(); snooze = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) romTable[i] = 16'h0000;
      for (int i = 0; i < L; i++)   romPipe[i]  = 16'h0000;
      romTable[5]  = 16'h3001;
      romTable[6]  = 16'h2001;
      romTable[7]  = 16'h2001;
      romTable[8]  = 16'h1000;
      romTable[9]  = 16'h0005;
      romTable[10] = 16'h1001;
      reset = 1'b1; secTick = 1'b0; run = 1'b0; loadReq = 1'b0;
      ack = 1'b0; snooze = 1'b0; patientId = 8'h00;
      cycle(); cycle();
      reset = 1'b0;
      cycle();
      cmpEn = 1'b1;
      chk("reset.state", int'(state), 0);
      chk("reset.remain", int'(remainingSec), 0);
      chk("reset.alarm", int'(alarm), 0);

      // Three acknowledged doses, 1-minute interval.
      run = 1'b1;
      pulseLoad(8'h05);
      chk("load.fetch", int'(state), 1);
      chk("load.romAddr", int'(romAddr), 5);
      cycle(); cycle();
      chk("load.stillFetch", int'(state), 1);
      cycle();
      chk("load.armed", int'(state), 2);
      chk("load.remain", int'(remainingSec), 60);
      sec(59);
      chk("count.remain1", int'(remainingSec), 1);
      chk("count.noAlarm", int'(alarm), 0);
      secTick = 1'b1; cycle(); secTick = 1'b0;
      chk("alarm.rise", int'(alarm), 1);
      chk("alarm.state", int'(state), 3);
      cycle();
      pulseAck();
      chk("ack.alarm", int'(alarm), 0);
      chk("ack.dose", int'(doseCount), 1);
      chk("ack.remain", int'(remainingSec), 60);
      repeat (2) begin sec(60); pulseAck(); end
      chk("ack3.done", int'(done), 1);
      chk("ack3.state", int'(state), 4);
      chk("ack3.dose", int'(doseCount), 3);

      // Two missed doses.
      pulseLoad(8'h06);
      repeat (3) cycle();
      chk("miss.cleared", int'(doseCount), 0);
      sec(60);
      chk("miss.alarm", int'(state), 3);
      sec(60);
      chk("miss1.missed", int'(missedCount), 1);
      chk("miss1.rearmed", int'(state), 2);
      chk("miss1.remain", int'(remainingSec), 60);
      sec(60); sec(60);
      chk("miss2.state", int'(state), 4);
      chk("miss2.missed", int'(missedCount), 2);
      chk("miss2.dose", int'(doseCount), 0);

      // ack coincides with the final timeout tick; then pause.
      pulseLoad(8'h07);
      repeat (3) cycle();
      sec(60); sec(59);
      chk("tie.preMissed", int'(missedCount), 0);
      secTick = 1'b1; ack = 1'b1; cycle(); secTick = 1'b0; ack = 1'b0;
      chk("tie.dose", int'(doseCount), 1);
      chk("tie.missed", int'(missedCount), 0);
      chk("tie.state", int'(state), 2);
      cycle();
      run = 1'b0;
      sec(10);
      chk("pause.remain", int'(remainingSec), 60);
      run = 1'b1;
      sec(3);
      chk("resume.remain", int'(remainingSec), 57);

      // Reload from ARMED: interval 0 clamps to one minute.
      pulseLoad(8'h08);
      repeat (3) cycle();
      chk("clamp.state", int'(state), 2);
      chk("clamp.remain", int'(remainingSec), 60);
      chk("clamp.dose", int'(doseCount), 0);
      sec(5);
      pulseLoad(8'h09);
      repeat (3) cycle();
      chk("zeroMax.state", int'(state), 4);
      chk("zeroMax.remain", int'(remainingSec), 0);

      // Snooze behaviour.
      pulseLoad(8'h0A);
      repeat (3) cycle();
      sec(60);
      chk("snz.alarm", int'(state), 3);
`ifdef DOSE_SCHED_SNOOZE_EN
      pulseSnooze();
      chk("snz.state", int'(state), 2);
      chk("snz.remain", int'(remainingSec), 300);
      sec(300);
      chk("snz.realarm", int'(state), 3);
      pulseSnooze();
      chk("snz2.ignored", int'(state), 3);
`else
      pulseSnooze();
      chk("snz.ignored", int'(state), 3);
`endif
      pulseAck();
      chk("snz.done", int'(state), 4);
      chk("snz.dose", int'(doseCount), 1);

      // Asynchronous reset in the middle of an alarm.
      pulseLoad(8'h05);
      repeat (3) cycle();
      sec(60); pulseAck(); sec(60);
      chk("rst.preAlarm", int'(alarm), 1);
      chk("rst.preDose", int'(doseCount), 1);
      #3 reset = 1'b1;
      #1;
      chk("rst.state", int'(state), 0);
      chk("rst.alarm", int'(alarm), 0);
      chk("rst.dose", int'(doseCount), 0);
      chk("rst.romAddr", int'(romAddr), 0);
      chk("rst.remain", int'(remainingSec), 0);
      cycle(); cycle();
      reset = 1'b0;
      ack = 1'b1; secTick = 1'b1; cycle(); ack = 1'b0; secTick = 1'b0;
      chk("idle.ignore", int'(state), 0);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
